// File: rtl/vend_pkg.sv
// Shared types and constants for the change dispenser: coin values in nickle units,
// payout state encoding and coin selector.
package vend_pkg;

  localparam int CHG_W   = 3;
  localparam int NICKLE  = 1;
  localparam int DIME    = 2;
  localparam int QUARTER = 5;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    RELEASE,
    GAP,
    DONE,
    JAM
  } disp_state_t;

  typedef enum logic [1:0] {
    COIN_Q,
    COIN_D,
    COIN_N
  } coin_t;

  function automatic logic [CHG_W-1:0] coin_value(input coin_t kind);
    logic [CHG_W-1:0] v;
    case (kind)
      COIN_Q:  v = CHG_W'(QUARTER);
      COIN_D:  v = CHG_W'(DIME);
      default: v = CHG_W'(NICKLE);
    endcase
    return v;
  endfunction

endpackage

// File: rtl/ack_timer.sv
// Clear/enable up-counter with a terminal-count flag against a runtime limit.
// tc_o is combinational from the count register; clear has priority over enable.
module ack_timer #(
  parameter int ACK_TIMEOUT = 16,
  parameter int W           = $clog2(ACK_TIMEOUT + 1)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] tc_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/change_dispenser.sv
// Latches change owed on a sell strobe and pays it out one coin per hopper handshake.
// Moore outputs; a missing ack for ACK_TIMEOUT cycles locks into JAM until reset.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int GAP_CYCLES  = 2
) (
  input  logic             clk,
  input  logic             rs,
  input  logic             s,
  input  logic [CHG_W-1:0] c,
  input  logic             quarter_empty,
  input  logic             dime_empty,
  input  logic             nickle_empty,
  input  logic             coin_ack,
  output logic             rel_quarter,
  output logic             rel_dime,
  output logic             rel_nickle,
  output logic             busy,
  output logic             done,
  output logic [CHG_W-1:0] short_change,
  output logic             jam
);

  localparam int TMAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  disp_state_t      state_q, state_d;
  logic [CHG_W-1:0] rem_q, rem_d;
  coin_t            coin_q, coin_d;

  logic             tmr_clr;
  logic             tmr_en;
  logic             tmr_tc;
  logic [TW-1:0]    tmr_tc_val;

  // One counter serves both the ack timeout and the motor-settle gap; the limit follows the state.
  ack_timer #(
    .ACK_TIMEOUT(TMAX),
    .W          (TW)
  ) u_timer (
    .clk_i   (clk),
    .rst_ni  (rs),
    .clr_i   (tmr_clr),
    .en_i    (tmr_en),
    .tc_val_i(tmr_tc_val),
    .tc_o    (tmr_tc)
  );

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    coin_d     = coin_q;
    tmr_clr    = 1'b1;
    tmr_en     = 1'b0;
    tmr_tc_val = TW'(ACK_TIMEOUT - 1);

    case (state_q)
      IDLE: begin
        if (s) begin
          rem_d   = c;
          state_d = (c != '0) ? SELECT : DONE;
        end
      end

      SELECT: begin
        // Greedy with fallback; a coin is only chosen if it cannot overpay.
        if (rem_q == '0) begin
          state_d = DONE;
        end else if (rem_q >= CHG_W'(QUARTER) && !quarter_empty) begin
          coin_d  = COIN_Q;
          state_d = RELEASE;
        end else if (rem_q >= CHG_W'(DIME) && !dime_empty) begin
          coin_d  = COIN_D;
          state_d = RELEASE;
        end else if (!nickle_empty) begin
          coin_d  = COIN_N;
          state_d = RELEASE;
        end else begin
          state_d = DONE;
        end
      end

      RELEASE: begin
        tmr_clr = 1'b0;
        tmr_en  = 1'b1;
        if (coin_ack) begin
          rem_d   = rem_q - coin_value(coin_q);
          state_d = GAP;
          tmr_clr = 1'b1;
        end else if (tmr_tc) begin
          state_d = JAM;
          tmr_clr = 1'b1;
        end
      end

      GAP: begin
        tmr_clr    = 1'b0;
        tmr_en     = 1'b1;
        tmr_tc_val = TW'(GAP_CYCLES - 1);
        if (tmr_tc) begin
          state_d = SELECT;
          tmr_clr = 1'b1;
        end
      end

      DONE: begin
        rem_d   = '0;
        state_d = IDLE;
      end

      JAM: begin
        state_d = JAM;
      end

      default: begin
        rem_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      state_q <= IDLE;
      rem_q   <= '0;
      coin_q  <= COIN_Q;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      coin_q  <= coin_d;
    end
  end

  assign rel_quarter  = (state_q == RELEASE) && (coin_q == COIN_Q);
  assign rel_dime     = (state_q == RELEASE) && (coin_q == COIN_D);
  assign rel_nickle   = (state_q == RELEASE) && (coin_q == COIN_N);
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign short_change = (state_q == DONE) ? rem_q : '0;
  assign jam          = (state_q == JAM);

endmodule
